// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI target endpoint, the bus peer of SpiMaster. SCLK, CS_n and MOSI are
// oversampled in the iClk domain, so every SPI event becomes a one-cycle strobe
// and all state lives on iClk. All four CPOL/CPHA modes are supported. Words
// are DATA_WIDTH bits, full duplex and MSB first.
//
// The parallel side has a one-word transmit holding register. The holding
// register is drained at every word boundary, so a host can keep several words
// flowing inside a single CS assertion. When the holding register is empty at
// a boundary, DEFAULT_TX is shifted out instead.
//
// Optional build macro: SPI_SLAVE_STATUS_EN
//    This macro adds iClrStatus, oUnderrun and oOverrun. Both flags are sticky:
//    - oUnderrun records that DEFAULT_TX was substituted at a mid-frame word
//      boundary.
//    - oOverrun records that a received word was replaced before the host
//      acknowledged it. The host acknowledges a word by issuing iLoad.
//    When a flag is set and cleared in the same cycle, the set wins.
//
// SCLK timing: each SCLK half-period must be at least SYNC_STAGES+3 iClk
// cycles. A shorter half-period lets edge strobes merge or overlap.
// -----------------------------------------------------------------------------
module spi_slave #(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    SYNC_STAGES = 2,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = '1
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic                  iCpol,
   input  logic                  iCpha,
   input  logic                  iSpiCs,
   input  logic                  iSpiClk,
   input  logic                  iSpiMosi,
   output logic                  oSpiMiso,
   output logic                  oSpiMisoOe,
   input  logic [DATA_WIDTH-1:0] iDin,
   input  logic                  iLoad,
   output logic                  oTxEmpty,
   output logic [DATA_WIDTH-1:0] oDout,
   output logic                  oValid,
`ifdef SPI_SLAVE_STATUS_EN
   input  logic                  iClrStatus,
   output logic                  oUnderrun,
   output logic                  oOverrun,
`endif
   output logic                  oBusy
);

   // The bit counter only has to reach DATA_WIDTH-1 before it wraps.
   localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic {
      IDLE,
      ACTIVE
   } SpiState;

   SpiState state;

   // Synchronizer chains and one-cycle-delayed copies for edge detection
   logic [SYNC_STAGES-1:0] csPipe;
   logic [SYNC_STAGES-1:0] sclkPipe;
   logic [SYNC_STAGES-1:0] mosiPipe;
   logic                   csDly;
   logic                   sclkDly;
   logic                   csNow;
   logic                   sclkNow;
   logic                   mosiNow;

   // Edge strobes in the iClk domain
   logic csFall;
   logic csRise;
   logic sclkRise;
   logic sclkFall;
   logic leadEdge;
   logic trailEdge;
   logic sampleEdge;
   logic shiftEdge;

   // Mode, latched when a frame starts
   logic cpolQ;
   logic cphaQ;

   // Datapath
   logic [CW-1:0]         bitCnt;
   logic [DATA_WIDTH-1:0] rxShift;
   logic [DATA_WIDTH-1:0] rxNext;
   logic [DATA_WIDTH-1:0] txShift;
   logic [DATA_WIDTH-1:0] holdReg;
   logic [DATA_WIDTH-1:0] nextWord;
   logic                  txEmpty;

   // Frame and word-boundary events
   logic frameStart;
   logic activeSample;
   logic activeShift;
   logic wordDone;
   logic boundary;
   logic consume;

   assign csNow   = csPipe[SYNC_STAGES-1];
   assign sclkNow = sclkPipe[SYNC_STAGES-1];
   assign mosiNow = mosiPipe[SYNC_STAGES-1];

   assign csFall   = csDly & ~csNow;
   assign csRise   = ~csDly & csNow;
   assign sclkRise = ~sclkDly & sclkNow;
   assign sclkFall = sclkDly & ~sclkNow;

   // CPOL selects which SCLK transition leads. CPHA selects whether the
   // leading edge or the trailing edge samples MOSI.
   assign leadEdge   = cpolQ ? sclkFall : sclkRise;
   assign trailEdge  = cpolQ ? sclkRise : sclkFall;
   assign sampleEdge = cphaQ ? trailEdge : leadEdge;
   assign shiftEdge  = cphaQ ? leadEdge  : trailEdge;

   // A CS rise ends the frame. It takes priority over any SCLK edge in the
   // same cycle, so that edge must not reach the datapath.
   assign frameStart   = (state == IDLE) & csFall;
   assign activeSample = (state == ACTIVE) & ~csRise & sampleEdge;
   assign activeShift  = (state == ACTIVE) & ~csRise & shiftEdge;
   assign wordDone     = activeSample & (bitCnt == LAST_BIT);

   // In CPHA=1 the next word is loaded when the final bit is sampled, which
   // places its MSB ready for the next leading edge. In CPHA=0 the next word
   // is loaded on the shift edge that follows the final sample; the counter
   // has already wrapped to zero when that edge arrives.
   assign boundary = cphaQ ? wordDone : (activeShift & (bitCnt == '0));
   assign consume  = frameStart | boundary;

   assign nextWord = txEmpty ? DEFAULT_TX : holdReg;
   assign rxNext   = {rxShift[DATA_WIDTH-2:0], mosiNow};

   // Bring the asynchronous bus pins into the iClk domain.
   // Reset loads the idle bus levels so that reset itself creates no edge.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         csPipe   <= '1;
         sclkPipe <= {SYNC_STAGES{iCpol}};
         mosiPipe <= '0;
         csDly    <= 1'b1;
         sclkDly  <= iCpol;
      end else begin
         csPipe   <= {csPipe[SYNC_STAGES-2:0], iSpiCs};
         sclkPipe <= {sclkPipe[SYNC_STAGES-2:0], iSpiClk};
         mosiPipe <= {mosiPipe[SYNC_STAGES-2:0], iSpiMosi};
         csDly    <= csNow;
         sclkDly  <= sclkNow;
      end
   end

   // Transmit holding register.
   // A consume and an iLoad in the same cycle hand the old word to the shifter
   // and keep the new word pending.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         holdReg <= '0;
         txEmpty <= 1'b1;
      end else if (iLoad) begin
         holdReg <= iDin;
         txEmpty <= 1'b0;
      end else if (consume) begin
         txEmpty <= 1'b1;
      end
   end

   assign oTxEmpty = txEmpty;

   // Frame state machine: mode latch, bit counter, RX/TX shifters and the
   // registered MISO, enable, valid and busy outputs.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state      <= IDLE;
         cpolQ      <= 1'b0;
         cphaQ      <= 1'b0;
         bitCnt     <= '0;
         rxShift    <= '0;
         txShift    <= '0;
         oSpiMiso   <= 1'b0;
         oSpiMisoOe <= 1'b0;
         oDout      <= '0;
         oValid     <= 1'b0;
         oBusy      <= 1'b0;
      end else begin
         oValid <= 1'b0;
         case (state)
            IDLE: begin
               if (csFall) begin
                  state      <= ACTIVE;
                  cpolQ      <= iCpol;
                  cphaQ      <= iCpha;
                  bitCnt     <= '0;
                  rxShift    <= '0;
                  txShift    <= nextWord;
                  oSpiMisoOe <= 1'b1;
                  oBusy      <= 1'b1;
                  if (!iCpha) begin
                     oSpiMiso <= nextWord[DATA_WIDTH-1];
                  end
               end
            end

            ACTIVE: begin
               if (csRise) begin
                  state      <= IDLE;
                  bitCnt     <= '0;
                  oSpiMisoOe <= 1'b0;
                  oSpiMiso   <= 1'b0;
                  oBusy      <= 1'b0;
               end else begin
                  if (sampleEdge) begin
                     rxShift <= rxNext;
                     if (bitCnt == LAST_BIT) begin
                        bitCnt <= '0;
                        oDout  <= rxNext;
                        oValid <= 1'b1;
                        if (cphaQ) begin
                           txShift <= nextWord;
                        end
                     end else begin
                        bitCnt <= bitCnt + CW'(1);
                     end
                  end
                  if (shiftEdge) begin
                     if (!cphaQ) begin
                        if (bitCnt == '0) begin
                           txShift  <= nextWord;
                           oSpiMiso <= nextWord[DATA_WIDTH-1];
                        end else begin
                           txShift  <= {txShift[DATA_WIDTH-2:0], 1'b0};
                           oSpiMiso <= txShift[DATA_WIDTH-2];
                        end
                     end else begin
                        oSpiMiso <= txShift[DATA_WIDTH-1];
                        txShift  <= {txShift[DATA_WIDTH-2:0], 1'b0};
                     end
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef SPI_SLAVE_STATUS_EN
   // Set when a received word is waiting for an iLoad acknowledge
   logic unacked;
   logic underrunSet;
   logic overrunSet;

   // An iLoad in the same cycle as oValid firing still counts as acknowledging
   // the word that oValid is about to replace.
   assign underrunSet = boundary & txEmpty;
   assign overrunSet  = wordDone & unacked & ~iLoad;

   // Sticky status flags. A set takes priority over a clear in the same cycle.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         oUnderrun <= 1'b0;
         oOverrun  <= 1'b0;
         unacked   <= 1'b0;
      end else begin
         if (underrunSet) begin
            oUnderrun <= 1'b1;
         end else if (iClrStatus) begin
            oUnderrun <= 1'b0;
         end
         if (overrunSet) begin
            oOverrun <= 1'b1;
         end else if (iClrStatus) begin
            oOverrun <= 1'b0;
         end
         if (wordDone) begin
            unacked <= 1'b1;
         end else if (iLoad) begin
            unacked <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//
// Directed bench for spi_slave. The bench acts as the SPI master, with an
// SCLK half-period of HALF iClk cycles. It also drives the parallel side.
// Expected words are worked out by hand from the bus protocol.
// When SPI_SLAVE_STATUS_EN is defined, the bench also exercises the status
// flags.
// -----------------------------------------------------------------------------
module tb_spi_slave;

   localparam int DW   = 8;
   localparam int SS   = 2;
   localparam int HALF = 10;

   logic          iClk = 1'b0;
   logic          iRst = 1'b1;
   logic          iCpol = 1'b0;
   logic          iCpha = 1'b0;
   logic          iSpiCs = 1'b1;
   logic          iSpiClk = 1'b0;
   logic          iSpiMosi = 1'b0;
   logic          oSpiMiso;
   logic          oSpiMisoOe;
   logic [DW-1:0] iDin = '0;
   logic          iLoad = 1'b0;
   logic          oTxEmpty;
   logic [DW-1:0] oDout;
   logic          oValid;
   logic          oBusy;
`ifdef SPI_SLAVE_STATUS_EN
   logic          iClrStatus = 1'b0;
   logic          oUnderrun;
   logic          oOverrun;
`endif

   int testsRun = 0;
   int testsFailed = 0;
   int validCount = 0;
   logic [DW-1:0] doutLog[$];

   spi_slave #(
      .DATA_WIDTH (DW),
      .SYNC_STAGES(SS),
      .DEFAULT_TX (8'hFF)
   ) dut (
      .iClk      (iClk),
      .iRst      (iRst),
      .iCpol     (iCpol),
      .iCpha     (iCpha),
      .iSpiCs    (iSpiCs),
      .iSpiClk   (iSpiClk),
      .iSpiMosi  (iSpiMosi),
      .oSpiMiso  (oSpiMiso),
      .oSpiMisoOe(oSpiMisoOe),
      .iDin      (iDin),
      .iLoad     (iLoad),
      .oTxEmpty  (oTxEmpty),
      .oDout     (oDout),
      .oValid    (oValid),
`ifdef SPI_SLAVE_STATUS_EN
      .iClrStatus(iClrStatus),
      .oUnderrun (oUnderrun),
      .oOverrun  (oOverrun),
`endif
      .oBusy     (oBusy)
   );

   // 100 MHz system clock
   always #5 iClk = ~iClk;

   // Log every oValid pulse and the word that came with it
   always @(negedge iClk) begin
      if (oValid) begin
         validCount++;
         doutLog.push_back(oDout);
      end
   end

   // Count one comparison and report it if the values differ
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic waitHalf();
      repeat (HALF) @(negedge iClk);
   endtask

   task automatic loadWord(input logic [DW-1:0] w);
      iDin  = w;
      iLoad = 1'b1;
      @(negedge iClk);
      iLoad = 1'b0;
      @(negedge iClk);
   endtask

   // Select the mode while the slave is idle, then assert CS
   task automatic csAssert(input logic cpol, input logic cpha);
      iCpol   = cpol;
      iCpha   = cpha;
      iSpiClk = cpol;
      repeat (6) @(negedge iClk);
      iSpiCs = 1'b0;
      waitHalf();
   endtask

   task automatic csDeassert();
      waitHalf();
      iSpiCs = 1'b1;
      repeat (8) @(negedge iClk);
      iSpiMosi = 1'b0;
   endtask

   // Clock nBits of mosiWord (MSB first) and collect MISO the way a master
   // would. If doLoad is set, loadVal is pulsed on iLoad at the start of bit 4.
   task automatic applyStimulus(input logic [DW-1:0] mosiWord, input int nBits,
                                input logic doLoad, input logic [DW-1:0] loadVal,
                                output logic [DW-1:0] misoWord);
      misoWord = '0;
      for (int i = DW - 1; i >= DW - nBits; i--) begin
         if (doLoad && i == 4) begin
            iDin  = loadVal;
            iLoad = 1'b1;
            @(negedge iClk);
            iLoad = 1'b0;
         end
         if (!iCpha) begin
            iSpiMosi = mosiWord[i];
            waitHalf();
            misoWord[i] = oSpiMiso;
            iSpiClk = ~iSpiClk;
            waitHalf();
            iSpiClk = ~iSpiClk;
         end else begin
            iSpiClk  = ~iSpiClk;
            iSpiMosi = mosiWord[i];
            waitHalf();
            misoWord[i] = oSpiMiso;
            iSpiClk = ~iSpiClk;
            waitHalf();
         end
      end
   endtask

`ifdef SPI_SLAVE_STATUS_EN
   task automatic clearStatus();
      iClrStatus = 1'b1;
      @(negedge iClk);
      iClrStatus = 1'b0;
      @(negedge iClk);
   endtask
`endif

   // Directed test sequence
   initial begin
      logic [DW-1:0] m1;
      logic [DW-1:0] m2;
      int v0;
      int n0;

      // Check the outputs while reset is held
      repeat (3) @(negedge iClk);
      checkOutput("rst miso", oSpiMiso, 0);
      checkOutput("rst oe", oSpiMisoOe, 0);
      checkOutput("rst txEmpty", oTxEmpty, 1);
      checkOutput("rst dout", oDout, 0);
      checkOutput("rst valid", oValid, 0);
      checkOutput("rst busy", oBusy, 0);
      iRst = 1'b0;
      repeat (3) @(negedge iClk);

      // Mode 3: send A5, receive 3C
      loadWord(8'hA5);
      checkOutput("m3 txEmpty after load", oTxEmpty, 0);
      csAssert(1'b1, 1'b1);
      checkOutput("m3 busy", oBusy, 1);
      checkOutput("m3 oe", oSpiMisoOe, 1);
      v0 = validCount;
      applyStimulus(8'h3C, 8, 1'b0, 8'h00, m1);
      csDeassert();
      checkOutput("m3 miso word", m1, 32'hA5);
      checkOutput("m3 valid pulses", validCount - v0, 1);
      checkOutput("m3 dout", oDout, 32'h3C);
      checkOutput("m3 txEmpty end", oTxEmpty, 1);
      checkOutput("m3 oe end", oSpiMisoOe, 0);
      checkOutput("m3 busy end", oBusy, 0);

      // Mode 0: the MSB must be on MISO before the first SCLK rise
      loadWord(8'h5A);
      iCpol   = 1'b0;
      iCpha   = 1'b0;
      iSpiClk = 1'b0;
      repeat (6) @(negedge iClk);
      iSpiCs = 1'b0;
      repeat (SS + 1) @(posedge iClk);
      #1;
      checkOutput("m0 early oe", oSpiMisoOe, 1);
      checkOutput("m0 early msb", oSpiMiso, 0);
      checkOutput("m0 early consume", oTxEmpty, 1);
      waitHalf();
      v0 = validCount;
      applyStimulus(8'hC3, 8, 1'b0, 8'h00, m1);
      csDeassert();
      checkOutput("m0 miso word", m1, 32'h5A);
      checkOutput("m0 dout", oDout, 32'hC3);
      checkOutput("m0 valid pulses", validCount - v0, 1);

      // Modes 1 and 2: two words in one frame, with a reload during word 1
      for (int m = 0; m < 2; m++) begin
         loadWord(8'hA5);
         csAssert(m == 1, m == 0);
         v0 = validCount;
         n0 = doutLog.size();
         applyStimulus(8'h12, 8, 1'b1, 8'h77, m1);
         applyStimulus(8'h34, 8, 1'b0, 8'h00, m2);
         csDeassert();
         checkOutput(m == 0 ? "m1 miso w1" : "m2 miso w1", m1, 32'hA5);
         checkOutput(m == 0 ? "m1 miso w2" : "m2 miso w2", m2, 32'h77);
         checkOutput(m == 0 ? "m1 valid pulses" : "m2 valid pulses", validCount - v0, 2);
         checkOutput(m == 0 ? "m1 dout w1" : "m2 dout w1", doutLog[n0], 32'h12);
         checkOutput(m == 0 ? "m1 dout w2" : "m2 dout w2", doutLog[n0 + 1], 32'h34);
         checkOutput(m == 0 ? "m1 txEmpty" : "m2 txEmpty", oTxEmpty, 1);
      end

      // Holding register empty: DEFAULT_TX fills both words
`ifdef SPI_SLAVE_STATUS_EN
      clearStatus();
      checkOutput("status cleared underrun", oUnderrun, 0);
      checkOutput("status cleared overrun", oOverrun, 0);
`endif
      csAssert(1'b0, 1'b0);
      applyStimulus(8'h00, 8, 1'b0, 8'h00, m1);
      applyStimulus(8'hFF, 8, 1'b0, 8'h00, m2);
      csDeassert();
      checkOutput("dflt miso w1", m1, 32'hFF);
      checkOutput("dflt miso w2", m2, 32'hFF);
      checkOutput("dflt dout", oDout, 32'hFF);
`ifdef SPI_SLAVE_STATUS_EN
      checkOutput("underrun set", oUnderrun, 1);
      checkOutput("overrun set", oOverrun, 1);
      clearStatus();
      checkOutput("underrun clr", oUnderrun, 0);
      checkOutput("overrun clr", oOverrun, 0);
`endif

      // CS raised after 5 bits: the partial word is dropped
      csAssert(1'b0, 1'b0);
      v0 = validCount;
      applyStimulus(8'hAA, 5, 1'b0, 8'h00, m1);
      csDeassert();
      checkOutput("abort no valid", validCount - v0, 0);
      checkOutput("abort dout kept", oDout, 32'hFF);
      checkOutput("abort oe", oSpiMisoOe, 0);
      checkOutput("abort miso", oSpiMiso, 0);
      csAssert(1'b0, 1'b0);
      v0 = validCount;
      applyStimulus(8'h81, 8, 1'b0, 8'h00, m1);
      csDeassert();
      checkOutput("after abort dout", oDout, 32'h81);
      checkOutput("after abort valid", validCount - v0, 1);

      // Reset asserted mid-word
      loadWord(8'h3C);
      csAssert(1'b0, 1'b0);
      applyStimulus(8'h5A, 4, 1'b0, 8'h00, m1);
      iRst    = 1'b1;
      iSpiCs  = 1'b1;
      iSpiClk = 1'b0;
      @(posedge iClk);
      #1;
      checkOutput("midrst miso", oSpiMiso, 0);
      checkOutput("midrst oe", oSpiMisoOe, 0);
      checkOutput("midrst txEmpty", oTxEmpty, 1);
      checkOutput("midrst dout", oDout, 0);
      checkOutput("midrst valid", oValid, 0);
      checkOutput("midrst busy", oBusy, 0);
      @(negedge iClk);
      iRst = 1'b0;
      repeat (5) @(negedge iClk);
      csAssert(1'b0, 1'b0);
      v0 = validCount;
      applyStimulus(8'h96, 8, 1'b0, 8'h00, m1);
      csDeassert();
      checkOutput("post rst dout", oDout, 32'h96);
      checkOutput("post rst miso", m1, 32'hFF);
      checkOutput("post rst valid", validCount - v0, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
